cell_upscaler: RTL

- Sits directly downstream of the Conway generation core's output AXI stream, which carries one colour word per cell in row-major order, with TLAST on the last cell of the frame.
- Replicates each cell into a SCALE×SCALE pixel block and emits a video-style AXI stream: TUSER marks start of frame, TLAST marks end of each output line.
- Buffers one cell row at a time and regenerates it SCALE times, so a small grid can drive a display pipeline directly.

---
 rtl/conware_pkg.sv | 24 ++
 rtl/cell_line_buffer.sv | 26 ++
 rtl/cell_upscaler.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/conware_pkg.sv
// Shared definitions for the Conway display path: FSM state encoding and width helpers.
package conware_pkg;

   localparam logic ST_FILL = 1'b0;
   localparam logic ST_EMIT = 1'b1;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      int unsigned v;
      r = 0;
      v = 1;
      while (v < n) begin
         v = v << 1;
         r = r + 1;
      end
      return r;
   endfunction

   // Counter width: never narrower than one bit, even for a range of one.
   function automatic int unsigned cnt_w(input int unsigned n);
      return clog2((n < 2) ? 2 : n);
   endfunction

endpackage

// File: rtl/cell_line_buffer.sv
// One cell row of colour words: single write port, asynchronous read port.
module cell_line_buffer
   import conware_pkg::*;
#(
   parameter  int unsigned DWIDTH = 32,
   parameter  int unsigned WIDTH  = 4,
   localparam int unsigned AW     = cnt_w(WIDTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DWIDTH-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DWIDTH-1:0] rdata
);

   logic [DWIDTH-1:0] mem [WIDTH];

   // Contents are only read after the whole row has been written, so no reset.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/cell_upscaler.sv
// Buffers one cell row and replays it SCALE times as SCALE x SCALE pixel blocks
// on a video-style AXI stream (TUSER = start of frame, TLAST = end of line).
module cell_upscaler
   import conware_pkg::*;
#(
   parameter int unsigned DWIDTH = 32,
   parameter int unsigned WIDTH  = 4,
   parameter int unsigned HEIGHT = 4,
   parameter int unsigned SCALE  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DWIDTH-1:0] S_AXIS_TDATA,
   input  logic              S_AXIS_TVALID,
   input  logic              S_AXIS_TLAST,
   output logic              S_AXIS_TREADY,
   output logic [DWIDTH-1:0] M_AXIS_TDATA,
   output logic              M_AXIS_TVALID,
   input  logic              M_AXIS_TREADY,
   output logic              M_AXIS_TLAST,
   output logic              M_AXIS_TUSER,
   output logic              frame_err
);

   localparam int unsigned CW    = cnt_w(WIDTH);
   localparam int unsigned XW    = cnt_w(WIDTH * SCALE);
   localparam int unsigned SW    = cnt_w(SCALE);
   localparam int unsigned RW    = cnt_w(HEIGHT);
   localparam int unsigned SHIFT = clog2(SCALE);
   localparam int unsigned XLAST = WIDTH * SCALE - 1;

   logic          state;
   logic [CW-1:0] col;
   logic [XW-1:0] x;
   logic [SW-1:0] sub;
   logic [RW-1:0] row;
   logic          short_frame;
   logic          s_ready_q;
   logic          m_valid_q;
   logic          m_last_q;
   logic          m_user_q;
   logic          err_q;

   logic          accept;
   logic          col_end;
   logic          row_end;
   logic          x_end;
   logic          sub_end;
   logic [CW-1:0] raddr;

   assign accept  = (state == ST_FILL) && S_AXIS_TVALID;
   assign col_end = (col == CW'(WIDTH - 1));
   assign row_end = (row == RW'(HEIGHT - 1));
   assign x_end   = (x == XW'(XLAST));
   assign sub_end = (sub == SW'(SCALE - 1));
   assign raddr   = CW'(x >> SHIFT);

   cell_line_buffer #(
      .DWIDTH (DWIDTH),
      .WIDTH  (WIDTH)
   ) u_line_buffer (
      .clk   (clk),
      .we    (accept),
      .waddr (col),
      .wdata (S_AXIS_TDATA),
      .raddr (raddr),
      .rdata (M_AXIS_TDATA)
   );

   // FSM, counters, TLAST check and registered handshake/flag outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_FILL;
         col         <= '0;
         x           <= '0;
         sub         <= '0;
         row         <= '0;
         short_frame <= 1'b0;
         s_ready_q   <= 1'b1;
         m_valid_q   <= 1'b0;
         m_last_q    <= 1'b0;
         m_user_q    <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state)
            ST_FILL: begin
               if (S_AXIS_TVALID) begin
                  if (S_AXIS_TLAST && !col_end) begin
                     // Partial row: drop it and restart the frame.
                     err_q <= 1'b1;
                     col   <= '0;
                     row   <= '0;
                  end else if (col_end) begin
                     col         <= '0;
                     state       <= ST_EMIT;
                     s_ready_q   <= 1'b0;
                     m_valid_q   <= 1'b1;
                     m_last_q    <= (XLAST == 0);
                     m_user_q    <= (row == '0);
                     err_q       <= (S_AXIS_TLAST != row_end);
                     short_frame <= S_AXIS_TLAST && !row_end;
                  end else begin
                     col <= col + CW'(1);
                  end
               end
            end
            default: begin
               if (M_AXIS_TREADY) begin
                  m_user_q <= 1'b0;
                  if (x_end) begin
                     x        <= '0;
                     m_last_q <= (XLAST == 0);
                     if (sub_end) begin
                        sub         <= '0;
                        state       <= ST_FILL;
                        s_ready_q   <= 1'b1;
                        m_valid_q   <= 1'b0;
                        m_last_q    <= 1'b0;
                        short_frame <= 1'b0;
                        row         <= (row_end || short_frame) ? '0 : row + RW'(1);
                     end else begin
                        sub <= sub + SW'(1);
                     end
                  end else begin
                     x        <= x + XW'(1);
                     m_last_q <= ((x + XW'(1)) == XW'(XLAST));
                  end
               end
            end
         endcase
      end
   end

   assign S_AXIS_TREADY = s_ready_q;
   assign M_AXIS_TVALID = m_valid_q;
   assign M_AXIS_TLAST  = m_last_q;
   assign M_AXIS_TUSER  = m_user_q;
   assign frame_err     = err_q;

endmodule
